// File: rtl/arashi_collect_buffer.sv
// Collect buffer for the 4-lane slot allocator: scatters same-cycle lane writes into
// a 32-entry circular store and drains them in allocation order over valid/ready.
module arashi_collect_buffer #(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [3:0]          in_valid,
    input  logic [4*DW-1:0]     in_data,
    output logic                in_ready,
    output logic [3:0]          alloc_wr,
    output logic [4:0]          alloc_offset,
    input  logic [19:0]         alloc_addr,
    input  logic [4:0]          alloc_offset_nx,
    output logic                out_valid,
    output logic [DW-1:0]       out_data,
    input  logic                out_ready,
    output logic [5:0]          level,
    output logic                alloc_err
);

    localparam int unsigned AW    = 5;
    localparam int unsigned LW    = 6;
    localparam int unsigned CW    = 3;
    localparam int unsigned LANES = 4;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [DW-1:0] mem [DEPTH];

    logic [CW-1:0] n_valid;
    logic [CW-1:0] n_acc;
    logic          slot_bad;
    logic          nx_bad;
    logic          accept;
    logic          pop;
    logic [LW-1:0] level_nx;

    // Lane count plus per-lane rank check against the allocator's returned slots
    always_comb begin
        n_valid  = '0;
        slot_bad = 1'b0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (in_valid[i]) begin
                if (alloc_addr[AW*i +: AW] != AW'(wr_ptr + AW'(n_valid))) begin
                    slot_bad = 1'b1;
                end
                n_valid = n_valid + CW'(1);
            end
        end
        nx_bad = (alloc_offset_nx != AW'(wr_ptr + AW'(n_valid)));
    end

    assign in_ready     = (level <= LW'(DEPTH - LANES));
    assign accept       = in_ready & (|in_valid);
    assign alloc_wr     = in_valid & {LANES{in_ready}};
    assign alloc_offset = wr_ptr;
    assign out_valid    = (level != '0);
    assign pop          = out_valid & out_ready;
    assign out_data     = mem[rd_ptr];
    assign n_acc        = accept ? n_valid : CW'(0);
    assign level_nx     = LW'(level + LW'(n_acc) - LW'(pop));

    // Pointer, occupancy and sticky error state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            alloc_err <= 1'b0;
        end else begin
            level <= level_nx;
            if (accept) begin
                wr_ptr <= AW'(wr_ptr + AW'(n_valid));
                if (slot_bad || nx_bad) begin
                    alloc_err <= 1'b1;
                end
            end
            if (pop) begin
                rd_ptr <= AW'(rd_ptr + AW'(1));
            end
        end
    end

    // Storage is not reset; lanes land at the allocator-supplied slots
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < LANES; i++) begin
            if (accept && in_valid[i]) begin
                mem[alloc_addr[AW*i +: AW]] <= in_data[DW*i +: DW];
            end
        end
    end

endmodule

// File: tb/tb_arashi_collect_buffer.sv
// Directed bench for arashi_collect_buffer with a stub allocator and an
// in-order expectation queue for drained data.
module tb_arashi_collect_buffer;

    localparam int unsigned DW = 32;

    logic            clk;
    logic            rst_n;
    logic [3:0]      in_valid;
    logic [4*DW-1:0] in_data;
    logic            in_ready;
    logic [3:0]      alloc_wr;
    logic [4:0]      alloc_offset;
    logic [19:0]     alloc_addr;
    logic [4:0]      alloc_offset_nx;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic            out_ready;
    logic [5:0]      level;
    logic            alloc_err;

    int tests;
    int fails;
    logic          inj_nx;
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] dctr;
    logic [4:0]    wr_before;
    logic [DW-1:0] held;

    arashi_collect_buffer #(.DW(DW), .DEPTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .alloc_wr(alloc_wr), .alloc_offset(alloc_offset),
        .alloc_addr(alloc_addr), .alloc_offset_nx(alloc_offset_nx),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .level(level), .alloc_err(alloc_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stub allocator: valid lanes get consecutive slots from the offset
    always_comb begin
        logic [4:0] c;
        c = '0;
        alloc_addr = '0;
        for (int i = 0; i < 4; i++) begin
            if (in_valid[i]) begin
                alloc_addr[5*i +: 5] = 5'(alloc_offset + c);
                c = 5'(c + 5'd1);
            end
        end
        alloc_offset_nx = 5'(alloc_offset + c + (inj_nx ? 5'd1 : 5'd0));
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One accepted write; expectation queue follows lane order
    task automatic wr(input logic [3:0] lanes);
        in_valid = lanes;
        for (int i = 0; i < 4; i++) begin
            in_data[DW*i +: DW] = dctr;
            if (lanes[i]) exp_q.push_back(dctr);
            dctr = dctr + 1;
        end
        step();
        in_valid = '0;
    endtask

    task automatic pop_check(input string tag);
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        out_ready = 1'b1;
        chk({tag, "_ov"}, 64'(out_valid), 64'd1);
        chk({tag, "_od"}, 64'(out_data), 64'(e));
        step();
        out_ready = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 40; k++) begin
            if (exp_q.size() != 0) pop_check(tag);
        end
        chk({tag, "_empty_lvl"}, 64'(level), 64'd0);
        chk({tag, "_empty_ov"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        tests = 0; fails = 0; inj_nx = 1'b0; dctr = 32'hA000_0000;
        in_valid = '0; in_data = '0; out_ready = 1'b0; rst_n = 1'b0;
        #12 rst_n = 1'b1;
        step();

        // 1: reset state, full 4-lane write, ordered drain
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_ov", 64'(out_valid), 64'd0);
        chk("rst_ir", 64'(in_ready), 64'd1);
        chk("rst_wr", 64'(alloc_wr), 64'd0);
        chk("rst_off", 64'(alloc_offset), 64'd0);
        chk("rst_err", 64'(alloc_err), 64'd0);
        in_valid = 4'b1111;
        #1 chk("t1_allocwr", 64'(alloc_wr), 64'hF);
        wr(4'b1111);
        chk("t1_level", 64'(level), 64'd4);
        chk("t1_off", 64'(alloc_offset), 64'd4);
        drain("t1");

        // 2: bring wr_ptr to 30, then a wrapping 3-lane write
        for (int k = 0; k < 6; k++) wr(4'b1111);
        wr(4'b0011);
        chk("t2_pre_off", 64'(alloc_offset), 64'd30);
        chk("t2_pre_lvl", 64'(level), 64'd26);
        wr(4'b1101);
        chk("t2_off", 64'(alloc_offset), 64'd1);
        chk("t2_lvl", 64'(level), 64'd29);
        chk("t2_ir", 64'(in_ready), 64'd0);
        drain("t2");

        // 3: near-full boundary
        for (int k = 0; k < 7; k++) wr(4'b1111);
        chk("t3_lvl28", 64'(level), 64'd28);
        chk("t3_ir28", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        void'(exp_q.pop_front());
        wr(4'b0001);
        out_ready = 1'b0;
        chk("t3_lvl_net", 64'(level), 64'd28);
        wr(4'b0001);
        chk("t3_lvl29", 64'(level), 64'd29);
        chk("t3_ir29", 64'(in_ready), 64'd0);
        wr_before = alloc_offset;
        held = dctr;
        in_valid = 4'b0001; in_data[DW-1:0] = held;
        #1 chk("t3_hold_wr", 64'(alloc_wr), 64'd0);
        step();
        chk("t3_hold_lvl", 64'(level), 64'd29);
        chk("t3_hold_off", 64'(alloc_offset), 64'(wr_before));
        out_ready = 1'b1;
        #1 chk("t3_pop_ir", 64'(in_ready), 64'd0);
        void'(exp_q.pop_front());
        step();
        out_ready = 1'b0;
        chk("t3_pop_lvl", 64'(level), 64'd28);
        chk("t3_pop_off", 64'(alloc_offset), 64'(wr_before));
        exp_q.push_back(held);
        dctr = dctr + 4;
        step();
        in_valid = '0;
        chk("t3_acc_lvl", 64'(level), 64'd29);
        drain("t3");

        // 4: allocator offset mismatch -> sticky error, pointer still local
        wr_before = alloc_offset;
        chk("t4_err0", 64'(alloc_err), 64'd0);
        inj_nx = 1'b1;
        wr(4'b1010);
        inj_nx = 1'b0;
        chk("t4_err1", 64'(alloc_err), 64'd1);
        chk("t4_off", 64'(alloc_offset), 64'(5'(wr_before + 5'd2)));
        wr(4'b0001);
        chk("t4_sticky", 64'(alloc_err), 64'd1);
        chk("t4_lvl", 64'(level), 64'd3);
        drain("t4");

        // 5: concurrent accept and pop at level 10
        wr(4'b1111); wr(4'b1111); wr(4'b0011);
        chk("t5_lvl10", 64'(level), 64'd10);
        chk("t5_od0", 64'(out_data), 64'(exp_q[0]));
        out_ready = 1'b1;
        void'(exp_q.pop_front());
        wr(4'b0111);
        out_ready = 1'b0;
        chk("t5_lvl12", 64'(level), 64'd12);
        chk("t5_od1", 64'(out_data), 64'(exp_q[0]));
        drain("t5");

        // 6: asynchronous reset mid-burst at level 17
        for (int k = 0; k < 4; k++) wr(4'b1111);
        wr(4'b0001);
        chk("t6_lvl17", 64'(level), 64'd17);
        in_valid = 4'b1111;
        #2 rst_n = 1'b0;
        #1;
        chk("t6_lvl", 64'(level), 64'd0);
        chk("t6_ov", 64'(out_valid), 64'd0);
        chk("t6_off", 64'(alloc_offset), 64'd0);
        chk("t6_ir", 64'(in_ready), 64'd1);
        chk("t6_err", 64'(alloc_err), 64'd0);
        in_valid = '0;
        exp_q.delete();
        #1 rst_n = 1'b1;
        step();
        wr(4'b1111);
        chk("t6_post_off", 64'(alloc_offset), 64'd4);
        drain("t6");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        fails++;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
